// File: rtl/adc_snapshot_buf.sv
// Multi-channel ADC snapshot engine: arms, waits for a trigger, then stores DEPTH
// decimated sample sets per channel into RAM for CPU readback.
module adc_snapshot_buf #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1024,
    parameter int DEC_W  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     smp_vld,
    input  logic [NUM_CH*DATA_W-1:0] smp_data,
    input  logic                     arm,
    input  logic                     abort,
    input  logic [1:0]               trig_mode,
    input  logic [CH_W-1:0]          trig_ch,
    input  logic [DATA_W-1:0]        trig_level,
    input  logic                     ext_trig,
    input  logic [DEC_W-1:0]         dec_ratio,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [AW-1:0]            rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     busy,
    output logic                     done,
    output logic [AW:0]              wr_count
);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       wr_count_q, wr_count_d;
    logic [DEC_W-1:0]  dec_q, dec_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              ext_prev_q, ext_prev_d;
    logic              first_q, first_d;
    logic [1:0]        mode_q, mode_d;
    logic [DATA_W-1:0] level_q, level_d;
    logic [DEC_W-1:0]  ratio_q, ratio_d;
    logic [CH_W-1:0]   tch_q, tch_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              wr_en;
    logic              trig_hit;
    logic [DATA_W-1:0] cur_smp;

    logic [DATA_W-1:0] mem [NUM_CH][DEPTH];

    always_comb begin
        cur_smp = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (tch_q == CH_W'(c)) cur_smp = smp_data[c*DATA_W +: DATA_W];
        end
    end

    // The first sample after arming only primes prev/ext history, except in immediate mode.
    always_comb begin
        trig_hit = 1'b0;
        case (mode_q)
            2'd0: trig_hit = 1'b1;
            2'd1: trig_hit = !first_q && ($signed(prev_q) < $signed(level_q))
                             && ($signed(cur_smp) >= $signed(level_q));
            2'd2: trig_hit = !first_q && ($signed(prev_q) >= $signed(level_q))
                             && ($signed(cur_smp) < $signed(level_q));
            default: trig_hit = !first_q && !ext_prev_q && ext_trig;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        dec_d      = dec_q;
        prev_d     = prev_q;
        ext_prev_d = ext_prev_q;
        first_d    = first_q;
        mode_d     = mode_q;
        level_d    = level_q;
        ratio_d    = ratio_q;
        tch_d      = tch_q;
        wr_en      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d    = S_ARMED;
                    wr_count_d = '0;
                    dec_d      = '0;
                    first_d    = 1'b1;
                    mode_d     = trig_mode;
                    level_d    = trig_level;
                    ratio_d    = dec_ratio;
                    tch_d      = trig_ch;
                end
            end
            S_ARMED: begin
                if (smp_vld) begin
                    prev_d     = cur_smp;
                    ext_prev_d = ext_trig;
                    first_d    = 1'b0;
                    if (trig_hit) begin
                        wr_en      = 1'b1;
                        wr_count_d = wr_count_q + 1'b1;
                        dec_d      = (ratio_q == '0) ? '0 : DEC_W'(1);
                        state_d    = (wr_count_d == (AW+1)'(DEPTH)) ? S_DONE : S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (smp_vld) begin
                    if (dec_q == '0) begin
                        wr_en      = 1'b1;
                        wr_count_d = wr_count_q + 1'b1;
                        if (wr_count_q == (AW+1)'(DEPTH - 1)) state_d = S_DONE;
                    end
                    dec_d = (dec_q == ratio_q) ? '0 : dec_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d    = S_IDLE;
            wr_count_d = '0;
            dec_d      = '0;
            wr_en      = 1'b0;
        end

        busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    always_comb begin
        rd_data_d = '0;
        if (int'(rd_ch) < NUM_CH) rd_data_d = mem[rd_ch][rd_addr];
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            wr_count_q <= '0;
            dec_q      <= '0;
            prev_q     <= '0;
            ext_prev_q <= 1'b0;
            first_q    <= 1'b0;
            mode_q     <= '0;
            level_q    <= '0;
            ratio_q    <= '0;
            tch_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_count_q <= wr_count_d;
            dec_q      <= dec_d;
            prev_q     <= prev_d;
            ext_prev_q <= ext_prev_d;
            first_q    <= first_d;
            mode_q     <= mode_d;
            level_q    <= level_d;
            ratio_q    <= ratio_d;
            tch_q      <= tch_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Sample RAM is not reset; reads see the pre-write contents on a same-address collision.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mem[c][wr_count_q[AW-1:0]] <= smp_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_count = wr_count_q;

endmodule
